alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs narrow (one pass) or wide (two pass) logic and
// add/sub operations through an external combinational ALU of width ALU_W.
// Requests and responses use valid/ready handshakes. Wide arithmetic chains
// the carry from the low pass into the high pass.
module alu_op_sequencer #(
  parameter int ALU_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_sel,
  input  logic               req_wide,
  input  logic               req_cin,
  input  logic [2*ALU_W-1:0] req_a,
  input  logic [2*ALU_W-1:0] req_b,
  output logic [ALU_W-1:0]   alu_a,
  output logic [ALU_W-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  output logic               alu_cin,
  input  logic [ALU_W-1:0]   alu_y,
  input  logic               alu_cout,
  input  logic               alu_neg,
  input  logic               alu_zero,
  input  logic               alu_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*ALU_W-1:0] rsp_y,
  output logic               rsp_cout,
  output logic               rsp_neg,
  output logic               rsp_zero,
  output logic               rsp_ovf,
  output logic               rsp_err
);

  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               wide_q, wide_d;
  logic [ALU_W-1:0]   a_hi_q, a_hi_d;
  logic [ALU_W-1:0]   b_hi_q, b_hi_d;
  logic [ALU_W-1:0]   alu_a_q, alu_a_d;
  logic [ALU_W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  logic               alu_cin_q, alu_cin_d;
  logic [2*ALU_W-1:0] rsp_y_q, rsp_y_d;
  logic               cout_q, cout_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               accept;

  // Codes 1000-1111 have no ALU meaning.
  function automatic logic is_illegal(input logic [3:0] sel);
    return sel[3];
  endfunction

  function automatic logic is_arith(input logic [3:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction

  // SUB is a + ~b + 1, so its low pass always gets carry-in 1.
  function automatic logic lo_carry_in(input logic [3:0] sel, input logic cin);
    logic c;
    c = 1'b0;
    if (sel == OP_ADD) c = cin;
    else if (sel == OP_SUB) c = 1'b1;
    return c;
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign accept    = req_valid && req_ready;

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign alu_cin = alu_cin_q;

  assign rsp_y    = rsp_y_q;
  assign rsp_cout = cout_q;
  assign rsp_neg  = neg_q;
  assign rsp_zero = zero_q;
  assign rsp_ovf  = ovf_q;
  assign rsp_err  = err_q;

  // Next-state logic: IDLE -> LO (legal) or RSP (illegal), LO -> HI/RSP, HI -> RSP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_illegal(req_sel) ? S_RSP : S_LO;
      S_LO:   state_d = wide_q ? S_HI : S_RSP;
      S_HI:   state_d = S_RSP;
      S_RSP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load operands on accept, capture each ALU pass.
  always_comb begin
    wide_d    = wide_q;
    a_hi_d    = a_hi_q;
    b_hi_d    = b_hi_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    alu_cin_d = alu_cin_q;
    rsp_y_d   = rsp_y_q;
    cout_d    = cout_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wide_d  = req_wide;
          a_hi_d  = req_a[2*ALU_W-1:ALU_W];
          b_hi_d  = req_b[2*ALU_W-1:ALU_W];
          rsp_y_d = '0;
          cout_d  = 1'b0;
          neg_d   = 1'b0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = is_illegal(req_sel);
          // The ALU bus is left untouched for an illegal opcode.
          if (!is_illegal(req_sel)) begin
            alu_a_d   = req_a[ALU_W-1:0];
            alu_b_d   = req_b[ALU_W-1:0];
            alu_sel_d = req_sel;
            alu_cin_d = lo_carry_in(req_sel, req_cin);
          end
        end
      end
      S_LO: begin
        rsp_y_d = {{ALU_W{1'b0}}, alu_y};
        cout_d  = alu_cout;
        neg_d   = alu_neg;
        zero_d  = alu_zero;
        ovf_d   = alu_ovf;
        if (wide_q) begin
          alu_a_d   = a_hi_q;
          alu_b_d   = b_hi_q;
          alu_cin_d = is_arith(alu_sel_q) ? alu_cout : 1'b0;
        end
      end
      S_HI: begin
        rsp_y_d = {alu_y, rsp_y_q[ALU_W-1:0]};
        cout_d  = alu_cout;
        neg_d   = alu_neg;
        ovf_d   = alu_ovf;
        zero_d  = zero_q & alu_zero;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wide_q    <= 1'b0;
      a_hi_q    <= '0;
      b_hi_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      alu_cin_q <= 1'b0;
      rsp_y_q   <= '0;
      cout_q    <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wide_q    <= wide_d;
      a_hi_q    <= a_hi_d;
      b_hi_q    <= b_hi_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      alu_cin_q <= alu_cin_d;
      rsp_y_q   <= rsp_y_d;
      cout_q    <= cout_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural stand-in ALU, a table of
// request/response vectors and hand-written multi-cycle sequences.
module tb_alu_op_sequencer;

  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_sel;
  logic          req_wide;
  logic          req_cin;
  logic [2*AW-1:0] req_a, req_b;
  logic [AW-1:0] alu_a, alu_b;
  logic [3:0]    alu_sel;
  logic          alu_cin;
  logic [AW-1:0] alu_y;
  logic          alu_cout, alu_neg, alu_zero, alu_ovf;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [2*AW-1:0] rsp_y;
  logic          rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err;

  alu_op_sequencer #(.ALU_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_wide(req_wide), .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU. For logic ops it reports cout=a[0], ovf=b[0] so that
  // flag pass-through is observable at the response.
  logic [AW:0] alu_sum;
  always_comb begin
    alu_sum  = '0;
    alu_y    = '0;
    alu_cout = alu_a[0];
    alu_ovf  = alu_b[0];
    case (alu_sel)
      4'd0: alu_y = alu_a & alu_b;
      4'd1: alu_y = alu_a | alu_b;
      4'd2: alu_y = ~alu_a;
      4'd3: alu_y = ~(alu_a | alu_b);
      4'd4: alu_y = alu_a ^ alu_b;
      4'd5: alu_y = ~(alu_a & alu_b);
      4'd6: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{AW{1'b0}}, alu_cin};
        alu_y    = alu_sum[AW-1:0];
        alu_cout = alu_sum[AW];
        alu_ovf  = (alu_a[AW-1] == alu_b[AW-1]) && (alu_y[AW-1] != alu_a[AW-1]);
      end
      4'd7: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {{AW{1'b0}}, alu_cin};
        alu_y    = alu_sum[AW-1:0];
        alu_cout = alu_sum[AW];
        alu_ovf  = (alu_a[AW-1] != alu_b[AW-1]) && (alu_y[AW-1] != alu_a[AW-1]);
      end
      default: alu_y = '0;
    endcase
    alu_neg  = alu_y[AW-1];
    alu_zero = (alu_y == '0);
  end

  typedef struct packed {
    logic [2*AW-1:0] y;
    logic cout, neg, zero, ovf, err;
  } rsp_t;

  typedef struct {
    logic [3:0]      sel;
    logic            wide;
    logic            cin;
    logic [2*AW-1:0] a, b;
    rsp_t            exp;
    int              hold;
  } vec_t;

  rsp_t sb_q[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   accept_cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mkv(input logic [3:0] sel, input logic wide, input logic cin,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] y, input logic cout, input logic neg,
                               input logic zero, input logic ovf, input logic err,
                               input int hold);
    vec_t v;
    v.sel = sel; v.wide = wide; v.cin = cin; v.a = a; v.b = b;
    v.exp = {y, cout, neg, zero, ovf, err};
    v.hold = hold;
    return v;
  endfunction

  function automatic int lat_of(input vec_t v);
    return v.exp.err ? 1 : (v.wide ? 3 : 2);
  endfunction

  function automatic rsp_t cur_rsp();
    return {rsp_y, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err};
  endfunction

  task automatic drive_req(input vec_t v);
    req_sel = v.sel; req_wide = v.wide; req_cin = v.cin;
    req_a = v.a; req_b = v.b; req_valid = 1'b1;
  endtask

  // Present a request in IDLE, let it be accepted, then scramble the inputs.
  task automatic start_req(input vec_t v, input string nm);
    drive_req(v);
    chk({nm, "_ready"}, req_ready, 1'b1);
    @(posedge clk); #1;
    accept_cyc = cyc;
    sb_q.push_back(v.exp);
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_sel = 4'($urandom); req_wide = 1'($urandom); req_cin = 1'($urandom);
  endtask

  task automatic wait_rsp(input int exp_lat, input string nm);
    for (int g = 0; g < 20 && !rsp_valid; g++) @(negedge clk);
    chk({nm, "_valid"}, rsp_valid, 1'b1);
    chk({nm, "_latency"}, cyc - accept_cyc + 1, exp_lat);
  endtask

  task automatic pop_cmp(input string nm);
    rsp_t e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    chk({nm, "_payload"}, cur_rsp(), e);
  endtask

  task automatic complete_rsp(input int hold, input string nm);
    for (int h = 0; h < hold; h++) begin
      chk({nm, "_hold"}, {rsp_valid, req_ready, cur_rsp()},
          {1'b1, 1'b0, (sb_q.size() > 0) ? sb_q[0] : '1});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    pop_cmp(nm);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, "_idle_after"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic do_vec(input vec_t v, input string nm);
    start_req(v, nm);
    wait_rsp(lat_of(v), nm);
    complete_rsp(v.hold, nm);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_ctrl_alu"}, {rsp_valid, req_ready, alu_a, alu_b, alu_sel, alu_cin},
        {1'b0, 1'b1, {AW{1'b0}}, {AW{1'b0}}, 4'h0, 1'b0});
    chk({nm, "_rsp"}, cur_rsp(), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_sel = '0; req_wide = 1'b0; req_cin = 1'b0; req_a = '0; req_b = '0;

    // sel wide cin a b | y cout neg zero ovf err | hold
    tbl.push_back(mkv(4'h0, 0, 1, 64'hFFFF_0000_F0F0_F0F0, 64'h1234_5678_FF00_FF00, 64'h0000_0000_F000_F000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(4'h1, 1, 0, 64'h8000_0000_0000_0001, 64'h0000_0001_0000_0000, 64'h8000_0001_0000_0001, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mkv(4'h2, 0, 0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0003, 64'h0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mkv(4'h3, 1, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(4'h4, 1, 0, 64'hAAAA_AAAA_5555_5555, 64'hAAAA_AAAA_5555_5555, 64'h0, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mkv(4'h5, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mkv(4'h6, 0, 0, 64'h0000_0000_7FFF_FFFF, 64'h1, 64'h0000_0000_8000_0000, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mkv(4'h6, 0, 1, 64'h5555_5555_FFFF_FFFF, 64'h0, 64'h0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(4'h6, 1, 0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(4'h7, 1, 0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkv(4'h7, 0, 0, 64'h0000_0000_8000_0000, 64'h1, 64'h0000_0000_7FFF_FFFF, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mkv(4'h7, 1, 0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(4'h6, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(4'h6, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mkv(4'h4, 0, 0, 64'h0000_0000_0F0F_0F0F, 64'h0000_0000_FF00_FF00, 64'h0000_0000_F00F_F00F, 1, 1, 0, 0, 0, 5));
    tbl.push_back(mkv(4'hA, 0, 0, 64'hDEAD_BEEF_0000_0001, 64'h1, 64'h0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(4'hF, 1, 1, 64'h1, 64'h1, 64'h0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mkv(4'h1, 1, 0, 64'h0000_0000_0000_0100, 64'h0, 64'h0000_0000_0000_0100, 0, 0, 0, 0, 0, 0));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) do_vec(tbl[i], $sformatf("vec%0d", i));

    // Wide ADD: carry from the low pass feeds the high pass
    v = mkv(4'h6, 1, 0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0, 0, 0, 0, 0, 0);
    start_req(v, "wadd");
    @(negedge clk);
    chk("wadd_lo_alu", {alu_a, alu_b, alu_sel, alu_cin}, {32'hFFFF_FFFF, 32'h1, 4'h6, 1'b0});
    @(negedge clk);
    chk("wadd_hi_alu", {alu_a, alu_b, alu_sel, alu_cin}, {32'h0, 32'h0, 4'h6, 1'b1});
    wait_rsp(3, "wadd");
    complete_rsp(0, "wadd");

    // Wide SUB of equal operands, then an illegal op must leave the ALU bus alone
    v = mkv(4'h7, 1, 0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1, 0, 1, 0, 0, 0);
    start_req(v, "wsub");
    @(negedge clk);
    chk("wsub_lo_alu", {alu_a, alu_sel, alu_cin}, {32'h9ABC_DEF0, 4'h7, 1'b1});
    @(negedge clk);
    chk("wsub_hi_alu", {alu_a, alu_cin}, {32'h1234_5678, 1'b1});
    wait_rsp(3, "wsub");
    complete_rsp(0, "wsub");
    v = mkv(4'hA, 0, 1, 64'h5A5A_5A5A_5A5A_5A5A, 64'h3, 64'h0, 0, 0, 0, 0, 1, 0);
    start_req(v, "ill");
    chk("ill_alu_kept", {alu_a, alu_b, alu_sel, alu_cin}, {32'h1234_5678, 32'h1234_5678, 4'h7, 1'b1});
    wait_rsp(1, "ill");
    complete_rsp(1, "ill");

    // Back-to-back: a request held during the transfer cycle is not taken then
    v = mkv(4'h0, 0, 0, 64'hF, 64'h3, 64'h3, 1, 0, 0, 1, 0, 0);
    start_req(v, "b2b_a");
    wait_rsp(2, "b2b_a");
    v = mkv(4'h1, 0, 0, 64'h1, 64'h2, 64'h3, 1, 0, 0, 0, 0, 0);
    drive_req(v);
    rsp_ready = 1'b1;
    pop_cmp("b2b_a");
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("b2b_not_taken", {rsp_valid, req_ready}, 2'b01);
    @(posedge clk); #1;
    accept_cyc = cyc;
    sb_q.push_back(v.exp);
    req_valid = 1'b0;
    chk("b2b_taken", req_ready, 1'b0);
    wait_rsp(2, "b2b_b");
    complete_rsp(0, "b2b_b");

    // Reset during the high pass aborts the operation
    v = mkv(4'h6, 1, 0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0, 0, 0, 0, 0, 0);
    start_req(v, "abort");
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_hi", {req_ready, rsp_valid, alu_cin}, 3'b001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    chk_cleared("abort");
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        seen = seen | rsp_valid;
      end
      chk("abort_no_rsp", seen, 1'b0);
    end
    v = mkv(4'h6, 1, 0, 64'h0000_0002_0000_0003, 64'h0000_0004_0000_0005, 64'h0000_0006_0000_0008, 0, 0, 0, 0, 0, 0);
    do_vec(v, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
